reg_file_mp: RTL and testbench

- Parametrised multi-port successor to the single-write/dual-read phased register file used by the datapath.
- Owns its own phase counter instead of taking an external counter.
- Supports NW write ports with deterministic collision priority, NR read ports, optional hard-wired zero register, optional same-edge write-to-read bypass, and a registered write-collision flag.
- Sits between decode (addresses) and ALU/writeback (data).

---
 rtl/reg_file_pkg.sv | 33 +++
 rtl/reg_phase_ctr.sv | 24 ++
 rtl/reg_file_mp.sv | 118 +++++++++++
 tb/tb_reg_file_mp.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared helpers for the phased multi-port register file: address sizing and
// write-port priority resolution.
package reg_file_pkg;

    localparam int MAX_NW = 32;

    typedef logic [MAX_NW-1:0] port_mask_t;

    typedef struct packed {
        logic       hit;
        logic       multi;
        logic [4:0] winner;
    } wr_res_t;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The highest-numbered requesting port wins; multi flags two or more requesters.
    function automatic wr_res_t resolve_write(input port_mask_t mask);
        wr_res_t res;
        res = '0;
        for (int k = 0; k < MAX_NW; k++) begin
            if (mask[k]) begin
                res.multi  = res.multi | res.hit;
                res.hit    = 1'b1;
                res.winner = 5'(k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_phase_ctr.sv
// Modulo-PHASES phase counter with advance enable and synchronous init.
module reg_phase_ctr #(
    parameter  int PHASES = 4,
    localparam int PW     = (PHASES > 1) ? $clog2(PHASES) : 1
) (
    input  logic          i_clk,
    input  logic          i_srst,
    input  logic          i_step,
    output logic [PW-1:0] o_phase
);

    logic [PW-1:0] r_phase;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_phase <= '0;
        end else if (i_step) begin
            r_phase <= (r_phase == PW'(PHASES - 1)) ? '0 : r_phase + 1'b1;
        end
    end

    assign o_phase = r_phase;

endmodule

// File: rtl/reg_file_mp.sv
// Phased multi-port register file: NW prioritised write ports, NR registered
// read ports, optional zero register and same-edge write-to-read bypass.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter  int N        = 8,
    parameter  int W        = 8,
    parameter  int NR       = 2,
    parameter  int NW       = 2,
    parameter  int PHASES   = 4,
    parameter  int WR_PHASE = 1,
    parameter  int RD_PHASE = 3,
    parameter  int ZERO_REG = 0,
    parameter  int BYPASS   = 1,
    localparam int AW       = addr_width(N),
    localparam int PW       = (PHASES > 1) ? $clog2(PHASES) : 1
) (
    input  logic             CLK,
    input  logic             init,
    input  logic             step,
    input  logic [NR*AW-1:0] raddr,
    input  logic [NW-1:0]    wen,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*W-1:0]  wdata,
    output logic [NR*W-1:0]  rdata,
    output logic [PW-1:0]    phase,
    output logic             wr_conflict
);

    generate
        if (N < 1 || NR < 1 || NW < 1 || NW > MAX_NW) begin : g_bad_size
            $error("reg_file_mp: N, NR, NW must be >= 1 and NW <= 32");
        end
        if (WR_PHASE < 0 || RD_PHASE < 0 || WR_PHASE >= PHASES || RD_PHASE >= PHASES) begin : g_bad_phase
            $error("reg_file_mp: WR_PHASE and RD_PHASE must be below PHASES");
        end
    endgenerate

    localparam bit SAME_EDGE = (WR_PHASE == RD_PHASE);

    typedef logic [N-1:0][W-1:0] reg_bank_t;

    reg_bank_t       r_regs;
    reg_bank_t       w_reg_next;
    logic [N-1:0]    w_multi;
    logic [NR*W-1:0] r_rdata;
    logic [NR*W-1:0] w_rdata_next;
    logic            r_conflict;
    logic [PW-1:0]   w_phase;
    logic            w_wr_edge;
    logic            w_rd_edge;

    reg_phase_ctr #(.PHASES(PHASES)) u_phase (
        .i_clk   (CLK),
        .i_srst  (init),
        .i_step  (step),
        .o_phase (w_phase)
    );

    assign w_wr_edge = step && (w_phase == PW'(WR_PHASE));
    assign w_rd_edge = step && (w_phase == PW'(RD_PHASE));

    // Per-register write resolution; w_reg_next equals r_regs off the write edge.
    for (genvar gi = 0; gi < N; gi++) begin : g_reg
        port_mask_t w_mask;
        wr_res_t    w_res;
        logic [W-1:0] w_next;

        always_comb begin
            w_mask = '0;
            for (int k = 0; k < NW; k++) begin
                w_mask[k] = w_wr_edge && wen[k] && (waddr[k*AW +: AW] == AW'(gi))
                            && (ZERO_REG == 0 || gi != 0);
            end
            w_res  = resolve_write(w_mask);
            w_next = r_regs[gi];
            for (int k = 0; k < NW; k++) begin
                if (w_res.hit && w_res.winner == 5'(k)) begin
                    w_next = wdata[k*W +: W];
                end
            end
        end

        assign w_reg_next[gi] = w_next;
        assign w_multi[gi]    = w_res.multi;
    end

    // Unmatched addresses (>= N, or 0 with the zero register) leave the lane at 0.
    always_comb begin
        w_rdata_next = '0;
        for (int j = 0; j < NR; j++) begin
            for (int i = (ZERO_REG != 0) ? 1 : 0; i < N; i++) begin
                if (raddr[j*AW +: AW] == AW'(i)) begin
                    w_rdata_next[j*W +: W] = (BYPASS != 0 && SAME_EDGE) ? w_reg_next[i] : r_regs[i];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (init) begin
            r_regs     <= '0;
            r_rdata    <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_regs     <= w_reg_next;
            r_conflict <= w_wr_edge && (|w_multi);
            if (w_rd_edge) begin
                r_rdata <= w_rdata_next;
            end
        end
    end

    assign rdata       = r_rdata;
    assign phase       = w_phase;
    assign wr_conflict = r_conflict;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: four configurations share one stimulus stream
// and are checked every cycle against an abstract register-file model.
`timescale 1ns/1ps
module tb_reg_file_mp;

    localparam int NI = 4;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       init;
    logic       step;
    logic [2:0] ra [3];
    logic [1:0] wen;
    logic [2:0] wa [2];
    logic [7:0] wd [2];

    logic [5:0]  raddr2;
    logic [8:0]  raddr3;
    logic [5:0]  waddr;
    logic [15:0] wdata;
    assign raddr2 = {ra[1], ra[0]};
    assign raddr3 = {ra[2], ra[1], ra[0]};
    assign waddr  = {wa[1], wa[0]};
    assign wdata  = {wd[1], wd[0]};

    logic [15:0] rd0, rd1;
    logic [23:0] rd2, rd3;
    logic [1:0]  ph0, ph1, ph2, ph3;
    logic        cf0, cf1, cf2, cf3;

    reg_file_mp u_d0 (
        .CLK(CLK), .init(init), .step(step), .raddr(raddr2), .wen(wen),
        .waddr(waddr), .wdata(wdata), .rdata(rd0), .phase(ph0), .wr_conflict(cf0));

    reg_file_mp #(.N(6), .ZERO_REG(1)) u_d1 (
        .CLK(CLK), .init(init), .step(step), .raddr(raddr2), .wen(wen),
        .waddr(waddr), .wdata(wdata), .rdata(rd1), .phase(ph1), .wr_conflict(cf1));

    reg_file_mp #(.NR(3), .WR_PHASE(2), .RD_PHASE(2), .BYPASS(1)) u_d2 (
        .CLK(CLK), .init(init), .step(step), .raddr(raddr3), .wen(wen),
        .waddr(waddr), .wdata(wdata), .rdata(rd2), .phase(ph2), .wr_conflict(cf2));

    reg_file_mp #(.NR(3), .WR_PHASE(2), .RD_PHASE(2), .BYPASS(0)) u_d3 (
        .CLK(CLK), .init(init), .step(step), .raddr(raddr3), .wen(wen),
        .waddr(waddr), .wdata(wdata), .rdata(rd3), .phase(ph3), .wr_conflict(cf3));

    // Configuration of each instance, as seen by the model.
    int c_n    [NI] = '{8, 6, 8, 8};
    int c_nr   [NI] = '{2, 2, 3, 3};
    int c_wp   [NI] = '{1, 1, 2, 2};
    int c_rp   [NI] = '{3, 3, 2, 2};
    int c_zero [NI] = '{0, 1, 0, 0};
    int c_byp  [NI] = '{1, 1, 1, 0};

    int m_reg [NI][8];
    int m_rd  [NI][3];
    int m_ph  [NI];
    int m_cf  [NI];

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what one clock edge does to configuration c, stated from the rules.
    task automatic model_edge(input int c);
        int nxt [8];
        int cnt [8];
        int a;
        if (init) begin
            for (int i = 0; i < 8; i++) m_reg[c][i] = 0;
            for (int j = 0; j < 3; j++) m_rd[c][j] = 0;
            m_ph[c] = 0;
            m_cf[c] = 0;
        end else if (step) begin
            for (int i = 0; i < 8; i++) begin
                nxt[i] = m_reg[c][i];
                cnt[i] = 0;
            end
            m_cf[c] = 0;
            if (m_ph[c] == c_wp[c]) begin
                for (int k = 0; k < 2; k++) begin
                    if (wen[k]) begin
                        a = int'(wa[k]);
                        if (a < c_n[c] && !(c_zero[c] != 0 && a == 0)) begin
                            cnt[a]++;
                            nxt[a] = int'(wd[k]);
                        end
                    end
                end
                for (int i = 0; i < 8; i++) if (cnt[i] > 1) m_cf[c] = 1;
            end
            if (m_ph[c] == c_rp[c]) begin
                for (int j = 0; j < c_nr[c]; j++) begin
                    a = int'(ra[j]);
                    if (a >= c_n[c] || (c_zero[c] != 0 && a == 0)) m_rd[c][j] = 0;
                    else if (c_byp[c] != 0 && c_wp[c] == c_rp[c]) m_rd[c][j] = nxt[a];
                    else m_rd[c][j] = m_reg[c][a];
                end
            end
            for (int i = 0; i < 8; i++) m_reg[c][i] = nxt[i];
            m_ph[c] = (m_ph[c] + 1) % 4;
        end else begin
            m_cf[c] = 0;
        end
    endtask

    always @(posedge CLK) begin
        for (int c = 0; c < NI; c++) model_edge(c);
    end

    function automatic logic [31:0] get_rd(input int c, input int j);
        case (c)
            0:       return 32'(rd0[j*8 +: 8]);
            1:       return 32'(rd1[j*8 +: 8]);
            2:       return 32'(rd2[j*8 +: 8]);
            default: return 32'(rd3[j*8 +: 8]);
        endcase
    endfunction

    function automatic logic [31:0] get_ph(input int c);
        case (c)
            0:       return 32'(ph0);
            1:       return 32'(ph1);
            2:       return 32'(ph2);
            default: return 32'(ph3);
        endcase
    endfunction

    function automatic logic [31:0] get_cf(input int c);
        case (c)
            0:       return 32'(cf0);
            1:       return 32'(cf1);
            2:       return 32'(cf2);
            default: return 32'(cf3);
        endcase
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int c = 0; c < NI; c++) begin
                check($sformatf("model_phase_d%0d", c), get_ph(c), m_ph[c]);
                check($sformatf("model_conflict_d%0d", c), get_cf(c), m_cf[c]);
                for (int j = 0; j < c_nr[c]; j++)
                    check($sformatf("model_rdata_d%0d_p%0d", c, j), get_rd(c, j), m_rd[c][j]);
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    // Advance (step must already be 1) until the default instance reaches phase p.
    task automatic goto_phase(input int p);
        for (int i = 0; i < 8 && m_ph[0] != p; i++) tick();
    endtask

    initial begin
        init = 1'b1; step = 1'b0; wen = 2'b00;
        for (int j = 0; j < 3; j++) ra[j] = 3'd0;
        for (int k = 0; k < 2; k++) begin wa[k] = 3'd0; wd[k] = 8'h00; end
        tick(); tick();
        chk_en = 1'b1;
        init = 1'b0;

        $display("txn random writes then reset");
        step = 1'b1;
        for (int t = 0; t < 8; t++) begin
            wen = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                wa[k] = 3'($urandom_range(0, 7));
                wd[k] = 8'($urandom_range(0, 255));
            end
            for (int j = 0; j < 3; j++) ra[j] = 3'($urandom_range(0, 7));
            tick();
        end
        init = 1'b1;
        wen = 2'b11;
        tick(); tick();
        check("reset_rdata_d0", 32'(rd0), 0);
        check("reset_rdata_d2", 32'(rd2), 0);
        check("reset_phase", 32'(ph0), 0);
        check("reset_conflict", 32'(cf0), 0);
        init = 1'b0; wen = 2'b00; ra[0] = 3'd5;
        repeat (4) tick();
        check("reset_read_reg5", 32'(rd0[7:0]), 0);

        $display("txn write 0xA5 to reg 3, read port 0");
        ra[0] = 3'd3;
        goto_phase(1);
        wen = 2'b01; wa[0] = 3'd3; wd[0] = 8'hA5; wa[1] = 3'd6;
        tick();
        wen = 2'b00;
        goto_phase(0);
        check("basic_read", 32'(rd0[7:0]), 32'hA5);
        step = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            check("hold_rdata", 32'(rd0[7:0]), 32'hA5);
            check("hold_phase", 32'(ph0), 0);
        end

        $display("txn collision on reg 2");
        step = 1'b1;
        goto_phase(1);
        wen = 2'b11; wa[0] = 3'd2; wa[1] = 3'd2; wd[0] = 8'h11; wd[1] = 8'h22;
        tick();
        check("conflict_set", 32'(cf0), 1);
        wen = 2'b00;
        tick();
        check("conflict_clear", 32'(cf0), 0);
        ra[0] = 3'd2;
        goto_phase(0);
        check("collision_winner", 32'(rd0[7:0]), 32'h22);

        $display("txn zero register and out-of-range writes");
        goto_phase(1);
        wen = 2'b11; wa[0] = 3'd0; wa[1] = 3'd0; wd[0] = 8'hFF; wd[1] = 8'hEE;
        tick();
        check("zero_reg_no_conflict", 32'(cf1), 0);
        check("addr0_conflict_d0", 32'(cf0), 1);
        wen = 2'b00;
        goto_phase(1);
        wen = 2'b10; wa[1] = 3'd7; wd[1] = 8'h77;
        tick();
        wen = 2'b00; ra[0] = 3'd0; ra[1] = 3'd7;
        goto_phase(0);
        check("zero_reg_read", 32'(rd1[7:0]), 0);
        check("oob_read", 32'(rd1[15:8]), 0);
        check("d0_reg0", 32'(rd0[7:0]), 32'hEE);
        check("d0_reg7", 32'(rd0[15:8]), 32'h77);

        $display("txn same-edge write/read of reg 4");
        goto_phase(2);
        wen = 2'b01; wa[0] = 3'd4; wd[0] = 8'h3C;
        for (int j = 0; j < 3; j++) ra[j] = 3'd4;
        tick();
        check("bypass_p0", 32'(rd2[7:0]), 32'h3C);
        check("bypass_p2", 32'(rd2[23:16]), 32'h3C);
        check("nobypass_old", 32'(rd3[7:0]), 0);
        wen = 2'b00;
        goto_phase(2);
        tick();
        check("nobypass_later", 32'(rd3[7:0]), 32'h3C);

        $display("txn reset during write phase");
        goto_phase(1);
        init = 1'b1; wen = 2'b01; wa[0] = 3'd5; wd[0] = 8'h5A;
        tick();
        check("midreset_phase", 32'(ph0), 0);
        check("midreset_phase_d2", 32'(ph2), 0);
        check("midreset_conflict", 32'(cf0), 0);
        init = 1'b0; wen = 2'b00; ra[0] = 3'd5; ra[1] = 3'd3;
        repeat (4) tick();
        check("midreset_reg5", 32'(rd0[7:0]), 0);
        check("midreset_reg3", 32'(rd0[15:8]), 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
